// File: rtl/uart_cmd_if.sv
// uart_cmd_if
// Turns a register read/write command into a byte stream for a UART
// transmitter and collects the read response from a UART receiver.
// Writes send {rw, addr} followed by NBYTES payload bytes, MSB byte first.
// Reads send the header only, then gather NBYTES received bytes. A gap
// longer than TIMEOUT_CYCLES between bytes ends the read with an error.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_rw            1 = write, 0 = read
//   cmd_addr          register address
//   cmd_wdata         write payload
//   tx_data, tx_en    byte to transmitter, one-cycle send strobe
//   tx_done           transmitter byte complete (level or pulse)
//   rx_data, rx_done  received byte, byte valid (level or pulse)
//   rsp_valid         one-cycle transaction-complete pulse
//   rsp_data          read data; zero for writes and timeouts
//   rsp_err           timeout flag, qualified by rsp_valid
//   rx_drop           one-cycle pulse when an unsolicited byte is discarded
//   busy              high whenever not idle
module uart_cmd_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int NBYTES         = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_rw,
  input  logic [ADDR_WIDTH-1:0]        cmd_addr,
  input  logic [NBYTES*DATA_WIDTH-1:0] cmd_wdata,
  output logic [DATA_WIDTH-1:0]        tx_data,
  output logic                         tx_en,
  input  logic                         tx_done,
  input  logic [DATA_WIDTH-1:0]        rx_data,
  input  logic                         rx_done,
  output logic                         rsp_valid,
  output logic [NBYTES*DATA_WIDTH-1:0] rsp_data,
  output logic                         rsp_err,
  output logic                         rx_drop,
  output logic                         busy
);

  localparam int PW      = NBYTES * DATA_WIDTH;
  localparam int IDX_W   = 3;
  localparam int TIMER_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0]   WR_LAST    = IDX_W'(NBYTES);
  localparam logic [IDX_W-1:0]   RX_LAST    = IDX_W'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    SEND    = 4'b0010,
    WAIT_TX = 4'b0100,
    WAIT_RX = 4'b1000
  } state_t;

  state_t               state_reg, state_next;
  logic                 rw_reg, rw_next;
  logic [PW-1:0]        wdata_reg, wdata_next;
  logic [IDX_W-1:0]     byte_idx_reg, byte_idx_next;
  logic [IDX_W-1:0]     rx_cnt_reg, rx_cnt_next;
  logic [TIMER_W-1:0]   timer_reg, timer_next;
  logic [DATA_WIDTH-1:0] tx_data_reg, tx_data_next;
  logic                 tx_en_reg, tx_en_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [PW-1:0]        rsp_data_reg, rsp_data_next;
  logic                 rsp_err_reg, rsp_err_next;
  logic                 rx_drop_reg, rx_drop_next;
  logic                 cmd_ready_reg, cmd_ready_next;
  logic                 busy_reg, busy_next;
  logic                 tx_done_d_reg, rx_done_d_reg;

  logic                 tx_edge, rx_edge;
  logic [DATA_WIDTH-1:0] payload_byte;
  logic [DATA_WIDTH-1:0] wbyte [NBYTES];

  assign tx_edge = tx_done & ~tx_done_d_reg;
  assign rx_edge = rx_done & ~rx_done_d_reg;

  // wbyte[0] is the most significant payload byte, i.e. the first one sent.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_wbyte
    assign wbyte[gi] = wdata_reg[(NBYTES-1-gi)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Byte that follows the one indexed by byte_idx_reg (index 0 is the header).
  always_comb begin
    payload_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (byte_idx_reg == IDX_W'(i)) payload_byte = wbyte[i];
    end
  end

  always_comb begin
    state_next     = state_reg;
    rw_next        = rw_reg;
    wdata_next     = wdata_reg;
    byte_idx_next  = byte_idx_reg;
    rx_cnt_next    = rx_cnt_reg;
    timer_next     = timer_reg;
    tx_data_next   = tx_data_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_valid_next = 1'b0;
    rx_drop_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready_reg) begin
          rw_next       = cmd_rw;
          wdata_next    = cmd_wdata;
          byte_idx_next = '0;
          tx_data_next  = DATA_WIDTH'({cmd_rw, cmd_addr});
          if (!cmd_rw) rsp_data_next = '0;
          state_next    = SEND;
        end
      end

      SEND: state_next = WAIT_TX;

      WAIT_TX: begin
        if (tx_edge) begin
          if (byte_idx_reg < (rw_reg ? WR_LAST : IDX_W'(0))) begin
            byte_idx_next = byte_idx_reg + IDX_W'(1);
            tx_data_next  = payload_byte;
            state_next    = SEND;
          end else if (rw_reg) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b0;
            rsp_data_next  = '0;
            state_next     = IDLE;
          end else begin
            timer_next  = TIMER_LOAD;
            rx_cnt_next = '0;
            state_next  = WAIT_RX;
          end
        end
      end

      WAIT_RX: begin
        // A received byte takes priority over a timer expiring in the same cycle.
        if (rx_edge) begin
          rsp_data_next = (rsp_data_reg << DATA_WIDTH) | PW'(rx_data);
          rx_cnt_next   = rx_cnt_reg + IDX_W'(1);
          timer_next    = TIMER_LOAD;
          if (rx_cnt_reg == RX_LAST) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b0;
            state_next     = IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_next = timer_reg - TIMER_W'(1);
          if (timer_reg == TIMER_W'(1)) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_data_next  = '0;
            state_next     = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // Bytes are only solicited while waiting for a read response.
    if (rx_edge && (state_reg != WAIT_RX)) rx_drop_next = 1'b1;

    tx_en_next     = (state_next == SEND);
    cmd_ready_next = (state_next == IDLE);
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rw_reg        <= 1'b0;
      wdata_reg     <= '0;
      byte_idx_reg  <= '0;
      rx_cnt_reg    <= '0;
      timer_reg     <= '0;
      tx_data_reg   <= '0;
      tx_en_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
      rx_drop_reg   <= 1'b0;
      cmd_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      tx_done_d_reg <= 1'b0;
      rx_done_d_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rw_reg        <= rw_next;
      wdata_reg     <= wdata_next;
      byte_idx_reg  <= byte_idx_next;
      rx_cnt_reg    <= rx_cnt_next;
      timer_reg     <= timer_next;
      tx_data_reg   <= tx_data_next;
      tx_en_reg     <= tx_en_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_err_reg   <= rsp_err_next;
      rx_drop_reg   <= rx_drop_next;
      cmd_ready_reg <= cmd_ready_next;
      busy_reg      <= busy_next;
      tx_done_d_reg <= tx_done;
      rx_done_d_reg <= rx_done;
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign busy      = busy_reg;
  assign tx_data   = tx_data_reg;
  assign tx_en     = tx_en_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;
  assign rx_drop   = rx_drop_reg;

endmodule

// File: tb/tb_uart_cmd_if.sv
// Directed and randomized bench for uart_cmd_if (NBYTES=2, timeout 100).
module tb_uart_cmd_if;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int NB = 2;
  localparam int TO = 100;
  localparam int PW = NB * DW;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rw    = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [PW-1:0] cmd_wdata = '0;
  logic [DW-1:0] tx_data;
  logic          tx_en;
  logic          tx_done   = 1'b0;
  logic [DW-1:0] rx_data   = '0;
  logic          rx_done   = 1'b0;
  logic          rsp_valid;
  logic [PW-1:0] rsp_data;
  logic          rsp_err;
  logic          rx_drop;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_if #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .NBYTES        (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .tx_data  (tx_data),
    .tx_en    (tx_en),
    .tx_done  (tx_done),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .rx_drop  (rx_drop),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command for one cycle, then scramble the inputs so that any
  // late sampling would show up in the transmitted bytes.
  task automatic issue_cmd(input logic rw, input logic [AW-1:0] addr,
                           input logic [PW-1:0] wdata, input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":ready"}, 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw    = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = PW'($urandom);
    check({tag, ":busy"}, 32'(busy), 1);
  endtask

  task automatic expect_tx(input logic [DW-1:0] exp, input string tag);
    int n = 0;
    while (tx_en !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":tx_en"}, 32'(tx_en), 1);
    check({tag, ":tx_data"}, 32'(tx_data), 32'(exp));
    @(negedge clk);
    check({tag, ":tx_en_1cyc"}, 32'(tx_en), 0);
    check({tag, ":tx_hold"}, 32'(tx_data), 32'(exp));
  endtask

  // Returns the number of the clock edge that captured the pulse.
  task automatic pulse_tx(output int ecyc);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    ecyc = cyc;
  endtask

  task automatic pulse_rx(input logic [DW-1:0] b, output int ecyc);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = DW'($urandom);
    ecyc = cyc;
  endtask

  task automatic wait_rsp(input int bound, output bit got, output int at);
    int n = 0;
    got = 1'b0;
    at  = 0;
    while (n < bound) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        at  = cyc;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  // Full transaction against the reference rules: header {rw,addr}, payload
  // MSB byte first for writes; reads return the received bytes with the
  // first one most significant, or error+zero data TO cycles after the last
  // event if fewer than NB bytes arrive.
  task automatic run_txn(input logic rw, input logic [AW-1:0] addr,
                         input logic [PW-1:0] wdata, input int tx_dly,
                         input int n_rx, input logic [4*DW-1:0] rx_bytes,
                         input string tag);
    logic [DW-1:0] exp_tx[$];
    logic [PW-1:0] exp_data;
    logic [DW-1:0] b;
    int  last_edge, at;
    bit  got, timed_out;
    exp_tx.push_back(DW'({rw, addr}));
    if (rw) begin
      for (int k = NB - 1; k >= 0; k--) exp_tx.push_back(DW'(wdata >> (DW * k)));
    end
    issue_cmd(rw, addr, wdata, tag);
    last_edge = cyc;
    foreach (exp_tx[i]) begin
      expect_tx(exp_tx[i], $sformatf("%s:byte%0d", tag, i));
      step(tx_dly);
      pulse_tx(last_edge);
    end
    exp_data = '0;
    if (!rw) begin
      for (int i = 0; i < n_rx; i++) begin
        step(int'($urandom_range(40, 1)));
        b = rx_bytes[i*DW +: DW];
        pulse_rx(b, last_edge);
        exp_data = (exp_data << DW) | PW'(b);
      end
    end
    timed_out = !rw && (n_rx < NB);
    wait_rsp(TO + 20, got, at);
    check({tag, ":rsp_valid"}, 32'(got), 1);
    if (got) begin
      check({tag, ":rsp_err"}, 32'(rsp_err), 32'(timed_out));
      check({tag, ":rsp_data"}, 32'(rsp_data), (rw || timed_out) ? 32'd0 : 32'(exp_data));
      check({tag, ":ready_at_rsp"}, 32'(cmd_ready), 1);
      if (timed_out) check({tag, ":timeout_latency"}, 32'(at - last_edge), TO);
      @(negedge clk);
      check({tag, ":rsp_pulse"}, 32'(rsp_valid), 0);
    end
    $display("txn %s rw=%0d addr=0x%0h wdata=0x%0h n_rx=%0d rsp_data=0x%0h err=%0d",
             tag, rw, addr, wdata, n_rx, rsp_data, rsp_err);
  endtask

  initial begin
    int  e, r, n;
    bit  got, early;
    logic          rw;
    logic [AW-1:0] addr;
    logic [PW-1:0] wd;
    logic [4*DW-1:0] rxb;
    int  nrx;

    // Reset values
    step(3);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rx_drop", 32'(rx_drop), 0);
    rst = 1'b0;
    step(2);

    // Directed write and read
    run_txn(1'b1, 7'h12, 16'hA55A, 19, 0, 32'h0, "wr_a55a");
    run_txn(1'b0, 7'h05, 16'h0, 3, 2, 32'h0000EFBE, "rd_beef");

    // Read with a single byte: times out TO cycles after it
    run_txn(1'b0, 7'h2A, 16'h0, 2, 1, 32'h00000011, "rd_timeout");

    // Unsolicited bytes in IDLE and WAIT_TX, command ignored while busy
    step(2);
    pulse_rx(8'h77, e);
    check("drop_idle", 32'(rx_drop), 1);
    check("drop_idle_no_rsp", 32'(rsp_valid), 0);
    check("drop_idle_state", 32'(cmd_ready), 1);
    step(1);
    check("drop_idle_1cyc", 32'(rx_drop), 0);
    issue_cmd(1'b0, 7'h33, 16'h0, "rd_drop");
    expect_tx(8'h33, "rd_drop:hdr");
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 7'h7F;
    cmd_wdata = 16'hFFFF;
    step(3);
    check("busy_cmd_no_tx", 32'(tx_en), 0);
    check("busy_cmd_tx_hold", 32'(tx_data), 32'h33);
    cmd_valid = 1'b0;
    pulse_rx(8'h77, e);
    check("drop_waittx", 32'(rx_drop), 1);
    check("drop_waittx_busy", 32'(busy), 1);
    check("drop_waittx_no_rsp", 32'(rsp_valid), 0);
    step(1);
    pulse_tx(r);
    step(2);
    pulse_rx(8'h12, e);
    step(3);
    pulse_rx(8'h34, e);
    wait_rsp(20, got, n);
    check("rd_drop:rsp_valid", 32'(got), 1);
    check("rd_drop:rsp_err", 32'(rsp_err), 0);
    check("rd_drop:rsp_data", 32'(rsp_data), 32'h1234);
    $display("txn rd_drop addr=0x33 rsp_data=0x%0h err=%0d", rsp_data, rsp_err);
    step(1);

    // Reset while tx_en is high drops it immediately
    issue_cmd(1'b1, 7'h01, 16'h0, "wr_rst_send");
    check("rst_send_tx_en_before", 32'(tx_en), 1);
    #1 rst = 1'b1;
    #1;
    check("rst_send_tx_en", 32'(tx_en), 0);
    check("rst_send_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Reset in WAIT_TX of a write with tx_done held high
    issue_cmd(1'b1, 7'h21, 16'h1357, "wr_rst");
    expect_tx(8'hA1, "wr_rst:hdr");
    step(3);
    tx_done = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy), 0);
    check("rst_async_ready", 32'(cmd_ready), 1);
    check("rst_async_tx_data", 32'(tx_data), 0);
    check("rst_async_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    step(3);
    rst = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || tx_en !== 1'b0) early = 1'b1;
    end
    check("rst_release_quiet", 32'(early), 0);
    issue_cmd(1'b1, 7'h21, 16'h1357, "wr_after_rst");
    expect_tx(8'hA1, "wr_after_rst:hdr");
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || busy !== 1'b1) early = 1'b1;
    end
    check("held_tx_done_no_edge", 32'(early), 0);
    tx_done = 1'b0;
    step(2);
    pulse_tx(r);
    expect_tx(8'h13, "wr_after_rst:b1");
    pulse_tx(r);
    expect_tx(8'h57, "wr_after_rst:b2");
    pulse_tx(r);
    check("wr_after_rst:rsp_valid", 32'(rsp_valid), 1);
    check("wr_after_rst:rsp_err", 32'(rsp_err), 0);
    $display("txn wr_after_rst addr=0x21 wdata=0x1357 rsp_valid=%0d", rsp_valid);
    step(1);

    // Rx edges exactly on the expiry cycle win and reload the timer
    issue_cmd(1'b0, 7'h44, 16'h0, "rd_edge");
    expect_tx(8'h44, "rd_edge:hdr");
    pulse_tx(r);
    early = 1'b0;
    while (cyc < r + TO - 1) begin
      if (rsp_valid !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    pulse_rx(8'hC3, e);
    check("rd_edge:no_early_rsp", 32'(early), 0);
    check("rd_edge:byte1_no_rsp", 32'(rsp_valid), 0);
    check("rd_edge:byte1_busy", 32'(busy), 1);
    while (cyc < e + TO - 1) begin
      if (rsp_valid !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    pulse_rx(8'h3C, e);
    check("rd_edge:no_early_rsp2", 32'(early), 0);
    check("rd_edge:rsp_valid", 32'(rsp_valid), 1);
    check("rd_edge:rsp_err", 32'(rsp_err), 0);
    check("rd_edge:rsp_data", 32'(rsp_data), 32'hC33C);
    $display("txn rd_edge addr=0x44 rsp_data=0x%0h err=%0d", rsp_data, rsp_err);
    step(1);

    // Randomized transactions
    for (int t = 0; t < 12; t++) begin
      rw   = 1'($urandom);
      addr = AW'($urandom);
      wd   = PW'($urandom);
      rxb  = $urandom;
      nrx  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(NB - 1, 0)) : NB;
      run_txn(rw, addr, wd, int'($urandom_range(6, 0)), nrx, rxb,
              $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
